muldiv_ctrl: RTL and testbench

// Multi-cycle sequencer for MULT/MULTU/DIV/DIVU. Sits beside the execute stage.

---
 rtl/muldiv_ctrl.sv | 132 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU sequencer with pipeline stall and HI/LO write
// One radix-2 step per cycle: shift-add multiply, restoring divide, sign fix-up on the final step.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_in,
    input  logic [1:0]       op_in,
    input  logic [WIDTH-1:0] src1_in,
    input  logic [WIDTH-1:0] src2_in,
    input  logic             cancel_in,
    output logic             arith_stall,
    output logic             busy_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             whilo_out,
    output logic             div_zero_out
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [1:0]           op_q;
    logic                 s1_q, s2_q, dz_q;
    logic [WIDTH-1:0]     a_sh, b_sh;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH-1:0]     hi_q, lo_q, hi_d, lo_d;

    logic                 accept, last, is_div, is_signed, sign_diff;
    logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot, rem;

    assign accept    = (state == IDLE) && start_in && !cancel_in;
    assign last      = (cnt == CW'(WIDTH - 1));
    assign is_div    = op_q[1];
    assign is_signed = !op_q[0];
    assign sign_diff = is_signed && (s1_q ^ s2_q);

    always_comb begin
        state_nxt   = state;
        arith_stall = 1'b0;
        unique case (state)
            IDLE: begin
                arith_stall = accept;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                arith_stall = 1'b1;
                if (cancel_in)  state_nxt = IDLE;
                else if (last)  state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_out     = (state != IDLE);
    assign whilo_out    = (state == DONE);
    assign div_zero_out = (state == DONE) && dz_q;
    assign hi_out       = hi_q;
    assign lo_out       = lo_q;

    // Multiply: a_sh is the multiplicand, b_sh shifts the multiplier out LSB first.
    // Divide: a_sh shifts the dividend in MSB first, b_sh holds the divisor.
    // The trial difference borrows into bit WIDTH exactly when rem_sh < divisor.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (b_sh[0] ? a_sh : {WIDTH{1'b0}})};
        rem_sh   = {acc[2*WIDTH-1:WIDTH], a_sh[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, b_sh};
        div_ge   = !rem_diff[WIDTH];
        if (is_div)
            acc_nxt = {(div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        else
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end

    // Divide-by-zero needs no special hi: restoring gives |src1|, and the dividend sign restores src1.
    always_comb begin
        prod = sign_diff ? (~acc_nxt + 1'b1) : acc_nxt;
        quot = sign_diff ? (~acc_nxt[WIDTH-1:0] + 1'b1) : acc_nxt[WIDTH-1:0];
        rem  = (is_signed && s1_q) ? (~acc_nxt[2*WIDTH-1:WIDTH] + 1'b1) : acc_nxt[2*WIDTH-1:WIDTH];
        if (is_div) begin
            hi_d = rem;
            lo_d = dz_q ? {WIDTH{1'b1}} : quot;
        end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dz_q  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q <= op_in;
                s1_q <= src1_in[WIDTH-1];
                s2_q <= src2_in[WIDTH-1];
                dz_q <= (src2_in == '0);
                a_sh <= (!op_in[0] && src1_in[WIDTH-1]) ? (~src1_in + 1'b1) : src1_in;
                b_sh <= (!op_in[0] && src2_in[WIDTH-1]) ? (~src2_in + 1'b1) : src2_in;
                acc  <= '0;
                cnt  <= '0;
            end else if (state == RUN && !cancel_in) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                if (is_div) a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                else        b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                if (last) begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_in = 1'b0;
    logic [1:0]  op_in = 2'b00;
    logic [31:0] src1_in = '0;
    logic [31:0] src2_in = '0;
    logic        cancel_in = 1'b0;
    logic        arith_stall, busy_out, whilo_out, div_zero_out;
    logic [31:0] hi_out, lo_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .start_in(start_in), .op_in(op_in),
        .src1_in(src1_in), .src2_in(src2_in), .cancel_in(cancel_in),
        .arith_stall(arith_stall), .busy_out(busy_out), .hi_out(hi_out),
        .lo_out(lo_out), .whilo_out(whilo_out), .div_zero_out(div_zero_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero with dividend-signed remainder.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        exp_dz = 1'b0;
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'b0, a} * {32'b0, b};
            default: p = '0;
        endcase
        if (op[1] == 1'b0) begin
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (b == 32'h0) begin
            exp_hi = a;
            exp_lo = 32'hFFFF_FFFF;
            exp_dz = 1'b1;
        end else if (op == 2'b11) begin
            exp_lo = a / b;
            exp_hi = a % b;
        end else begin
            q = sa / sb;
            r = sa % sb;
            p = 64'(q);
            exp_lo = p[31:0];
            p = 64'(r);
            exp_hi = p[31:0];
        end
    endtask

    // Starts an op in the current cycle (pre=1: current cycle is a DONE, start waits one cycle).
    // Holds start with junk operands for a few RUN cycles; returns in the DONE cycle.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit pre);
        start_in = 1'b1; op_in = op; src1_in = a; src2_in = b; cancel_in = 1'b0;
        #1;
        if (pre) begin
            chk({tag, "_done_stall"}, 32'(arith_stall), 32'd0);
            tick();
        end
        chk({tag, "_c0_stall"}, 32'(arith_stall), 32'd1);
        chk({tag, "_c0_busy"}, 32'(busy_out), 32'd0);
        model(op, a, b);
        tick();
        for (int c = 1; c <= 32; c++) begin
            if (c < 5) begin
                op_in = 2'($urandom); src1_in = $urandom; src2_in = $urandom;
            end else begin
                start_in = 1'b0;
            end
            #1;
            if (arith_stall !== 1'b1 || busy_out !== 1'b1 || whilo_out !== 1'b0 || c == 1 || c == 32) begin
                chk({tag, "_run_stall"}, 32'(arith_stall), 32'd1);
                chk({tag, "_run_busy"}, 32'(busy_out), 32'd1);
                chk({tag, "_run_whilo"}, 32'(whilo_out), 32'd0);
            end
            tick();
        end
        chk({tag, "_whilo"}, 32'(whilo_out), 32'd1);
        chk({tag, "_stall33"}, 32'(arith_stall), 32'd0);
        chk({tag, "_hi"}, hi_out, exp_hi);
        chk({tag, "_lo"}, lo_out, exp_lo);
        chk({tag, "_dz"}, 32'(div_zero_out), 32'(exp_dz));
    endtask

    task automatic after_done(input string tag);
        tick();
        chk({tag, "_whilo_off"}, 32'(whilo_out), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy_out), 32'd0);
        chk({tag, "_hi_hold"}, hi_out, exp_hi);
        chk({tag, "_lo_hold"}, lo_out, exp_lo);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hi0"}, hi_out, 32'd0);
        chk({tag, "_lo0"}, lo_out, 32'd0);
        chk({tag, "_whilo0"}, 32'(whilo_out), 32'd0);
        chk({tag, "_dz0"}, 32'(div_zero_out), 32'd0);
        chk({tag, "_busy0"}, 32'(busy_out), 32'd0);
        chk({tag, "_stall0"}, 32'(arith_stall), 32'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        #3;
        chk_zero("reset");
        #10;
        rstn = 1'b1;
        tick();

        do_op("mult_7xm3", 2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0);
        after_done("mult_7xm3");
        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        after_done("multu_max");
        do_op("divu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
        after_done("divu_100_7");
        do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        after_done("div_m7_2");
        do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        after_done("div_ovf");
        do_op("div_5_0", 2'b10, 32'd5, 32'd0, 1'b0);
        after_done("div_5_0");
        do_op("div_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0, 1'b0);
        after_done("div_m5_0");
        do_op("divu_x_0", 2'b11, 32'h8000_0001, 32'd0, 1'b0);
        after_done("divu_x_0");
        do_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op("b2b_mult", 2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
        after_done("b2b_mult");

        start_in = 1'b1; cancel_in = 1'b1; op_in = 2'b01; src1_in = 32'd3; src2_in = 32'd4;
        #1;
        chk("idle_cancel_stall", 32'(arith_stall), 32'd0);
        tick();
        chk("idle_cancel_busy", 32'(busy_out), 32'd0);
        cancel_in = 1'b0;

        op_in = 2'b01; src1_in = 32'hAAAA_5555; src2_in = 32'h0F0F_F0F0; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        cancel_in = 1'b1;
        tick();
        chk("cancel_busy", 32'(busy_out), 32'd0);
        chk("cancel_whilo", 32'(whilo_out), 32'd0);
        chk("cancel_hi_hold", hi_out, exp_hi);
        chk("cancel_lo_hold", lo_out, exp_lo);
        do_op("after_cancel", 2'b10, 32'h8765_4321, 32'h0000_1234, 1'b0);
        after_done("after_cancel");

        for (int n = 0; n < 12; n++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if (n % 3 == 2) rb = rb >> $urandom_range(8, 30);
            do_op($sformatf("rnd%0d", n), rop, ra, rb, 1'b0);
            after_done($sformatf("rnd%0d", n));
        end

        op_in = 2'b00; src1_in = 32'd123; src2_in = 32'd456; start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        rstn = 1'b0;
        #1;
        chk_zero("midrun_reset");
        tick();
        chk_zero("reset_held");
        rstn = 1'b1;
        tick();
        chk("post_reset_busy", 32'(busy_out), 32'd0);
        chk("post_reset_whilo", 32'(whilo_out), 32'd0);
        do_op("post_reset", 2'b11, 32'hFFFF_FFFF, 32'd16, 1'b0);
        after_done("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
